// File: rtl/seq_scan_pkg.sv
// Shared types and default constants for the serial pattern-scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_scan_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_PLEN  = 4;
  localparam logic [DEF_PLEN-1:0] DEF_PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a bit-position field for a word of w bits; never zero.
  function automatic int pos_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial matcher: PLEN-bit history shift register, saturating fill counter, pattern compare.
// Latency: hit is combinational for the bit being shifted in this cycle (reflects the next history).
// Backpressure: none; advances only when shift_en is high, clr has priority over shifting.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int              PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = PLEN'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  input  logic bit_in,
  output logic hit
);

  localparam int FW = $clog2(PLEN + 1);

  logic [PLEN-1:0] hist_q;
  logic [PLEN-1:0] hist_nxt;
  logic [FW-1:0]   fill_q;
  logic [FW-1:0]   fill_nxt;

  generate
    if (PLEN == 1) begin : g_one
      assign hist_nxt = bit_in;
    end else begin : g_multi
      assign hist_nxt = {hist_q[PLEN-2:0], bit_in};
    end
  endgenerate

  // Fill count stops at PLEN: once the history is full it stays full.
  assign fill_nxt = (fill_q == FW'(PLEN)) ? fill_q : fill_q + FW'(1);

  // A hit is flagged for the shift that completes the pattern, so the caller
  // can register it on the same edge that moves the bit in.
  assign hit = shift_en && (hist_nxt == PATTERN) && (fill_nxt == FW'(PLEN));

  // History and fill count update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_nxt;
      fill_q <= fill_nxt;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts a word, streams it MSB first into the matcher, reports hit count / first hit position / found.
// Latency: out_valid rises WIDTH cycles after the accept edge; one word every WIDTH+2 cycles at best.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. SEQ_CARRY_EN keeps history across words.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int              WIDTH   = DEF_WIDTH,
  parameter int              PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = PLEN'(DEF_PATTERN),
  localparam int             CW      = $clog2(WIDTH + 1),
  localparam int             PW      = pos_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    match_cnt,
  output logic [PW-1:0]    first_pos,
  output logic             found,
  output logic             match_pulse
);

  state_t           state_q;
  state_t           state_nxt;
  logic [WIDTH-1:0] word_q;
  logic [PW-1:0]    idx_q;
  logic             accept;
  logic             shift_en;
  logic             last_bit;
  logic             hit;
  logic             core_clr;

  assign accept   = in_valid && in_ready;
  assign last_bit = (idx_q == PW'(WIDTH - 1));
  assign found    = (match_cnt != '0);

`ifdef SEQ_CARRY_EN
  // History spans word boundaries; only reset clears it.
  assign core_clr = 1'b0;
`else
  // Every word is scanned from an empty history.
  assign core_clr = accept;
`endif

  seq_match_core #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (core_clr),
    .shift_en (shift_en),
    .bit_in   (word_q[WIDTH-1]),
    .hit      (hit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state: accept -> shift WIDTH bits -> hold result until taken.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept)                 state_nxt = SHIFT;
      SHIFT:   if (last_bit)               state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // State-decoded handshake and shift enable.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      SHIFT:   shift_en  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Captured word shifts left so the MSB always feeds the matcher; idx tracks the stream position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      word_q <= in_word;
      idx_q  <= '0;
    end else if (shift_en) begin
      word_q <= word_q << 1;
      if (!last_bit) begin
        idx_q <= idx_q + PW'(1);
      end
    end
  end

  // Result accumulation: count hits, latch position of the first, pulse once per hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt   <= '0;
      first_pos   <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= hit;
      if (accept) begin
        match_cnt <= '0;
        first_pos <= '0;
      end else if (hit) begin
        match_cnt <= match_cnt + CW'(1);
        if (match_cnt == '0) begin
          first_pos <= idx_q;
        end
      end
    end
  end

endmodule
